// File: rtl/exception_sequencer.sv
`timescale 1ns/1ps
// Commit-stage exception/trap sequencer: picks the highest-priority event at commit and walks
// the CP0 update, pipeline flush and fetch redirect through a three-state FSM.
module exception_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [4:0]  EXC_INT    = 5'h00,
  parameter logic [4:0]  EXC_TRAP   = 5'h0D
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_s0_valid,
  input  logic        i_s0_exc,
  input  logic [4:0]  i_s0_exc_code,
  input  logic        i_s0_trap,
  input  logic [31:0] i_s0_pc,
  input  logic        i_s0_bd,
  input  logic [31:0] i_s0_badva,
  input  logic        i_s1_valid,
  input  logic        i_s1_exc,
  input  logic [4:0]  i_s1_exc_code,
  input  logic        i_s1_trap,
  input  logic [31:0] i_s1_pc,
  input  logic        i_s1_bd,
  input  logic [31:0] i_s1_badva,
  input  logic        i_s0_eret,
  input  logic        i_int_pending,
  input  logic [31:0] i_cp0_epc,
  output logic        o_cp0_we,
  output logic [31:0] o_cp0_epc,
  output logic [4:0]  o_cp0_exc_code,
  output logic        o_cp0_bd,
  output logic [31:0] o_cp0_badva,
  output logic        o_cp0_exl_clr,
  output logic        o_flush,
  output logic        o_stall_req,
  output logic        o_redir_valid,
  output logic [31:0] o_redir_pc,
  input  logic        i_redir_ready
);

  typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic        r_is_eret;
  logic [31:0] r_epc;
  logic [4:0]  r_code;
  logic        r_bd;
  logic [31:0] r_badva;
  logic [31:0] r_redir_pc;

  logic        w_hit;
  logic        w_eret;
  logic [4:0]  w_code;
  logic [31:0] w_pc;
  logic        w_bd;
  logic [31:0] w_badva;
  logic [31:0] w_epc;
  logic        w_s0_evt;
  logic        w_s1_evt;

  assign w_s0_evt = i_s0_valid & (i_s0_exc | i_s0_trap);
  assign w_s1_evt = i_s1_valid & (i_s1_exc | i_s1_trap);

  // Priority: interrupt > slot0 exception/trap > ERET > slot1 exception/trap.
  always_comb begin
    w_hit   = 1'b0;
    w_eret  = 1'b0;
    w_code  = 5'h00;
    w_pc    = 32'h0;
    w_bd    = 1'b0;
    w_badva = 32'h0;
    if (i_int_pending && i_s0_valid) begin
      w_hit   = 1'b1;
      w_code  = EXC_INT;
      w_pc    = i_s0_pc;
      w_bd    = i_s0_bd;
      w_badva = i_s0_badva;
    end else if (w_s0_evt) begin
      w_hit   = 1'b1;
      w_code  = i_s0_exc ? i_s0_exc_code : EXC_TRAP;
      w_pc    = i_s0_pc;
      w_bd    = i_s0_bd;
      w_badva = i_s0_badva;
    end else if (i_s0_valid && i_s0_eret) begin
      w_hit  = 1'b1;
      w_eret = 1'b1;
    end else if (w_s1_evt) begin
      w_hit   = 1'b1;
      w_code  = i_s1_exc ? i_s1_exc_code : EXC_TRAP;
      w_pc    = i_s1_pc;
      w_bd    = i_s1_bd;
      w_badva = i_s1_badva;
    end
  end

  assign w_epc = w_bd ? (w_pc - 32'd4) : w_pc;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:     if (w_hit) w_state_d = StFlush;
      StFlush:    w_state_d = StRedirect;
      StRedirect: if (i_redir_ready) w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_is_eret  <= 1'b0;
      r_epc      <= 32'h0;
      r_code     <= 5'h00;
      r_bd       <= 1'b0;
      r_badva    <= 32'h0;
      r_redir_pc <= 32'h0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && w_hit) begin
        r_is_eret  <= w_eret;
        r_epc      <= w_epc;
        r_code     <= w_code;
        r_bd       <= w_bd;
        r_badva    <= w_badva;
        r_redir_pc <= w_eret ? i_cp0_epc : EXC_VECTOR;
      end
    end
  end

  always_comb begin
    o_cp0_we      = 1'b0;
    o_cp0_exl_clr = 1'b0;
    o_flush       = 1'b0;
    o_stall_req   = 1'b0;
    o_redir_valid = 1'b0;
    unique case (r_state)
      StFlush: begin
        o_flush       = 1'b1;
        o_stall_req   = 1'b1;
        o_cp0_we      = ~r_is_eret;
        o_cp0_exl_clr = r_is_eret;
      end
      StRedirect: begin
        o_stall_req   = 1'b1;
        o_redir_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_cp0_epc      = r_epc;
  assign o_cp0_exc_code = r_code;
  assign o_cp0_bd       = r_bd;
  assign o_cp0_badva    = r_badva;
  assign o_redir_pc     = r_redir_pc;

endmodule

// File: tb/tb_exception_sequencer.sv
`timescale 1ns/1ps
// Randomized and directed bench for exception_sequencer; expected timelines come from an
// event-level priority model rather than the cycle-level state machine.
module tb_exception_sequencer;

  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam logic [4:0]  INTC = 5'h00;
  localparam logic [4:0]  TRAP = 5'h0D;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s0_exc, s0_trap, s0_bd, s0_eret;
  logic [4:0]  s0_code;
  logic [31:0] s0_pc, s0_badva;
  logic        s1_valid, s1_exc, s1_trap, s1_bd;
  logic [4:0]  s1_code;
  logic [31:0] s1_pc, s1_badva;
  logic        int_pending;
  logic [31:0] cp0_epc_in;
  logic        cp0_we, cp0_bd, cp0_exl_clr, flush, stall_req, redir_valid, redir_ready;
  logic [31:0] cp0_epc_out, cp0_badva, redir_pc;
  logic [4:0]  cp0_code;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        v0, e0, t0, bd0, eret, intp, v1, e1, t1, bd1;
    logic [4:0]  code0, code1;
    logic [31:0] pc0, pc1, bva0, bva1, epc;
  } ev_t;

  typedef struct {
    logic        hit, eret, bd;
    logic [4:0]  code;
    logic [31:0] epc, badva, target;
  } exp_t;

  exception_sequencer dut (
    .i_clk(clk), .i_rst(rst),
    .i_s0_valid(s0_valid), .i_s0_exc(s0_exc), .i_s0_exc_code(s0_code), .i_s0_trap(s0_trap),
    .i_s0_pc(s0_pc), .i_s0_bd(s0_bd), .i_s0_badva(s0_badva),
    .i_s1_valid(s1_valid), .i_s1_exc(s1_exc), .i_s1_exc_code(s1_code), .i_s1_trap(s1_trap),
    .i_s1_pc(s1_pc), .i_s1_bd(s1_bd), .i_s1_badva(s1_badva),
    .i_s0_eret(s0_eret), .i_int_pending(int_pending), .i_cp0_epc(cp0_epc_in),
    .o_cp0_we(cp0_we), .o_cp0_epc(cp0_epc_out), .o_cp0_exc_code(cp0_code), .o_cp0_bd(cp0_bd),
    .o_cp0_badva(cp0_badva), .o_cp0_exl_clr(cp0_exl_clr), .o_flush(flush),
    .o_stall_req(stall_req), .o_redir_valid(redir_valid), .o_redir_pc(redir_pc),
    .i_redir_ready(redir_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Event-level reference: which event wins and what CP0/fetch should see.
  function automatic exp_t model(input ev_t x);
    exp_t m;
    logic [31:0] pc;
    m.hit = 1'b0; m.eret = 1'b0; m.bd = 1'b0; m.code = 5'h00;
    m.epc = 32'h0; m.badva = 32'h0; m.target = VEC; pc = 32'h0;
    if (x.intp && x.v0) begin
      m.hit = 1'b1; m.code = INTC; pc = x.pc0; m.bd = x.bd0; m.badva = x.bva0;
    end else if (x.v0 && (x.e0 || x.t0)) begin
      m.hit = 1'b1; m.code = x.e0 ? x.code0 : TRAP; pc = x.pc0; m.bd = x.bd0; m.badva = x.bva0;
    end else if (x.v0 && x.eret) begin
      m.hit = 1'b1; m.eret = 1'b1; m.target = x.epc;
    end else if (x.v1 && (x.e1 || x.t1)) begin
      m.hit = 1'b1; m.code = x.e1 ? x.code1 : TRAP; pc = x.pc1; m.bd = x.bd1; m.badva = x.bva1;
    end
    m.epc = m.bd ? pc - 32'd4 : pc;
    return m;
  endfunction

  function automatic ev_t quiet();
    ev_t x;
    x.v0 = 0; x.e0 = 0; x.t0 = 0; x.bd0 = 0; x.eret = 0; x.intp = 0;
    x.v1 = 0; x.e1 = 0; x.t1 = 0; x.bd1 = 0; x.code0 = 0; x.code1 = 0;
    x.pc0 = 0; x.pc1 = 0; x.bva0 = 0; x.bva1 = 0; x.epc = 0;
    return x;
  endfunction

  function automatic ev_t rand_ev();
    ev_t x;
    x.v0 = ($urandom_range(0, 3) != 0); x.e0 = ($urandom_range(0, 3) == 0);
    x.t0 = ($urandom_range(0, 3) == 0); x.bd0 = ($urandom_range(0, 1) == 0);
    x.eret = ($urandom_range(0, 3) == 0); x.intp = ($urandom_range(0, 5) == 0);
    x.v1 = ($urandom_range(0, 3) != 0); x.e1 = ($urandom_range(0, 2) == 0);
    x.t1 = ($urandom_range(0, 2) == 0); x.bd1 = ($urandom_range(0, 1) == 0);
    x.code0 = 5'($urandom); x.code1 = 5'($urandom);
    x.pc0 = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
    x.pc1 = $urandom; x.bva0 = $urandom; x.bva1 = $urandom; x.epc = $urandom;
    return x;
  endfunction

  task automatic apply(input ev_t x);
    s0_valid = x.v0; s0_exc = x.e0; s0_trap = x.t0; s0_bd = x.bd0; s0_code = x.code0;
    s0_pc = x.pc0; s0_badva = x.bva0; s0_eret = x.eret; int_pending = x.intp;
    s1_valid = x.v1; s1_exc = x.e1; s1_trap = x.t1; s1_bd = x.bd1; s1_code = x.code1;
    s1_pc = x.pc1; s1_badva = x.bva1; cp0_epc_in = x.epc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".flush"}, {31'b0, flush}, 32'd0);
    chk({tag, ".stall"}, {31'b0, stall_req}, 32'd0);
    chk({tag, ".we"}, {31'b0, cp0_we}, 32'd0);
    chk({tag, ".exl"}, {31'b0, cp0_exl_clr}, 32'd0);
    chk({tag, ".rvalid"}, {31'b0, redir_valid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_idle(tag);
    chk({tag, ".epc"}, cp0_epc_out, 32'd0);
    chk({tag, ".code"}, {27'b0, cp0_code}, 32'd0);
    chk({tag, ".bd"}, {31'b0, cp0_bd}, 32'd0);
    chk({tag, ".badva"}, cp0_badva, 32'd0);
    chk({tag, ".rpc"}, redir_pc, 32'd0);
  endtask

  // One event: detect edge, FLUSH cycle, REDIRECT for delay+1 cycles, back in IDLE.
  task automatic episode(input string tag, input ev_t x, input int delay, input bit noise);
    exp_t m;
    m = model(x);
    apply(x);
    tick();
    if (!m.hit) begin
      check_idle({tag, ".none"});
    end else begin
      chk({tag, ".flush"}, {31'b0, flush}, 32'd1);
      chk({tag, ".fstall"}, {31'b0, stall_req}, 32'd1);
      chk({tag, ".we"}, {31'b0, cp0_we}, {31'b0, ~m.eret});
      chk({tag, ".exl"}, {31'b0, cp0_exl_clr}, {31'b0, m.eret});
      chk({tag, ".frv"}, {31'b0, redir_valid}, 32'd0);
      if (!m.eret) begin
        chk({tag, ".epc"}, cp0_epc_out, m.epc);
        chk({tag, ".code"}, {27'b0, cp0_code}, {27'b0, m.code});
        chk({tag, ".bd"}, {31'b0, cp0_bd}, {31'b0, m.bd});
        chk({tag, ".badva"}, cp0_badva, m.badva);
      end
      apply(noise ? rand_ev() : quiet());
      redir_ready = ($urandom_range(0, 1) == 0);
      tick();
      for (int k = 0; k <= delay; k++) begin
        chk({tag, ".rv"}, {31'b0, redir_valid}, 32'd1);
        chk({tag, ".rpc"}, redir_pc, m.target);
        chk({tag, ".rstall"}, {31'b0, stall_req}, 32'd1);
        chk({tag, ".rflush"}, {31'b0, flush}, 32'd0);
        chk({tag, ".rwe"}, {31'b0, cp0_we | cp0_exl_clr}, 32'd0);
        redir_ready = (k == delay);
        if (k == delay) apply(quiet());
        else if (noise) apply(rand_ev());
        tick();
      end
      redir_ready = 1'b0;
      check_idle({tag, ".post"});
    end
  endtask

  initial begin
    ev_t x;
    rst = 1'b1;
    redir_ready = 1'b0;
    apply(quiet());
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    x = quiet(); x.v0 = 1; x.t0 = 1; x.pc0 = 32'h8000_0100;
    episode("trap0", x, 0, 1'b0);

    x = quiet(); x.v0 = 1; x.v1 = 1; x.e1 = 1; x.code1 = 5'h04; x.pc1 = 32'h8000_0204;
    x.bd1 = 1; x.bva1 = 32'h13;
    episode("exc1", x, 1, 1'b0);

    x = quiet(); x.v0 = 1; x.intp = 1; x.e0 = 1; x.code0 = 5'h0A; x.pc0 = 32'h8000_0300;
    episode("intr", x, 0, 1'b0);

    x = quiet(); x.v0 = 1; x.eret = 1; x.epc = 32'h8000_0040;
    episode("eret", x, 3, 1'b0);

    x = quiet(); x.v0 = 1; x.e0 = 1; x.t0 = 1; x.code0 = 5'h05; x.bd0 = 1; x.pc0 = 32'h0;
    episode("wrap", x, 0, 1'b0);

    // Slot0 exception keeps arriving during the sequence; it must not start a second one.
    x = quiet(); x.v0 = 1; x.e0 = 1; x.code0 = 5'h0C; x.pc0 = 32'h8000_0500;
    apply(x);
    tick();
    tick();
    chk("busy.rv", {31'b0, redir_valid}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("busy.we", {31'b0, cp0_we}, 32'd0);
      chk("busy.rv2", {31'b0, redir_valid}, 32'd1);
    end
    apply(quiet());
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    check_idle("busy.post");

    // Reset while waiting in REDIRECT.
    x = quiet(); x.v0 = 1; x.t0 = 1; x.pc0 = 32'h8000_0600; x.bva0 = 32'h77;
    apply(x);
    tick();
    apply(quiet());
    tick();
    chk("rstmid.rv", {31'b0, redir_valid}, 32'd1);
    rst = 1'b1;
    redir_ready = 1'b1;
    tick();
    rst = 1'b0;
    redir_ready = 1'b0;
    check_all_zero("rstmid");
    tick();
    check_idle("rstmid.after");

    for (int i = 0; i < 150; i++) begin
      episode("rand", rand_ev(), $urandom_range(0, 3), ($urandom_range(0, 1) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
